// File: rtl/demod_pkg.sv
// Shared types and default parameters for the demodulator sequencing controller.
package demod_pkg;

    localparam int          DEF_WIDTH     = 16;
    localparam logic [31:0] DEF_SYNC_WORD = 32'h7FFF_8000;
    localparam int          DEF_PKT_LEN   = 1024;
    localparam int          DEF_LATENCY   = 7;
    localparam int          DEF_TIMEOUT   = 64;

    // Advance counter must hold PKT_LEN + LATENCY (max 65535 + 255).
    localparam int ADV_CNT_W = 17;
    localparam int GAP_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

endpackage

// File: rtl/demod_seq_ctrl_if.sv
// Sample-stream and datapath-control bundle between the sequencer and its neighbours.
interface demod_seq_ctrl_if
    import demod_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic                    in_valid_i;
    logic signed [2*WIDTH-1:0] data_i;
    logic                    start_o;
    logic signed [2*WIDTH-1:0] sample_o;
    logic                    valid_o;
    logic                    clr_o;
    logic                    busy_o;
    logic                    err_o;
    logic [15:0]             pkt_cnt_o;

    modport master (
        output in_valid_i, data_i,
        input  start_o, sample_o, valid_o, clr_o, busy_o, err_o, pkt_cnt_o
    );

    modport slave (
        input  in_valid_i, data_i,
        output start_o, sample_o, valid_o, clr_o, busy_o, err_o, pkt_cnt_o
    );
endinterface

// File: rtl/demod_seq_ctrl_gap_timer.sv
// Loadable, clearable down-counter that saturates at zero; tc flags the last count.
module gap_timer
    import demod_pkg::*;
#(
    parameter int W = GAP_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // One more idle cycle would exhaust the allowance.
    assign tc = (cnt_q == W'(1));
endmodule

// File: rtl/demod_seq_ctrl.sv
// Packet sequencer: detects the sync word, feeds payload into a fixed-latency datapath,
// flushes the pipeline and aborts on input starvation.
//
//   state | meaning
//   IDLE  | waiting for sync word, datapath quiet
//   FILL  | accepting payload while the pipeline fills (k <= LATENCY)
//   RUN   | accepting payload with output samples emerging
//   FLUSH | pushing LATENCY zero samples to drain the pipeline
//   ABORT | one-cycle timeout exit: err_o and clr_o asserted
module demod_seq_ctrl
    import demod_pkg::*;
#(
    parameter int                 WIDTH     = DEF_WIDTH,
    parameter logic [2*WIDTH-1:0] SYNC_WORD = DEF_SYNC_WORD,
    parameter int                 PKT_LEN   = DEF_PKT_LEN,
    parameter int                 LATENCY   = DEF_LATENCY,
    parameter int                 TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    demod_seq_ctrl_if.slave      bus
);
    localparam logic [ADV_CNT_W-1:0] LAT_C = ADV_CNT_W'(LATENCY);
    localparam logic [ADV_CNT_W-1:0] LEN_C = ADV_CNT_W'(PKT_LEN);
    localparam logic [ADV_CNT_W-1:0] END_C = ADV_CNT_W'(PKT_LEN + LATENCY);
    localparam logic [GAP_CNT_W-1:0] TMO_C = GAP_CNT_W'(TIMEOUT);

    state_t                  state_q, state_d;
    logic [ADV_CNT_W-1:0]    k_q, k_d, k_adv;
    logic                    adv;
    logic signed [2*WIDTH-1:0] sample;
    logic                    gap_clr, gap_load, gap_dec, gap_tc;
    logic                    valid_d, clr_d, err_d, pkt_inc;
    logic                    valid_q, clr_q, err_q;
    logic [15:0]             pkt_cnt_q;

    assign k_adv = k_q + ADV_CNT_W'(1);

    gap_timer #(.W(GAP_CNT_W)) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (gap_clr),
        .load     (gap_load),
        .load_val (TMO_C),
        .dec      (gap_dec),
        .tc       (gap_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            valid_q   <= 1'b0;
            clr_q     <= 1'b0;
            err_q     <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            valid_q   <= valid_d;
            clr_q     <= clr_d;
            err_q     <= err_d;
            if (pkt_inc) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        adv      = 1'b0;
        sample   = '0;
        gap_clr  = 1'b0;
        gap_load = 1'b0;
        gap_dec  = 1'b0;
        clr_d    = 1'b0;
        err_d    = 1'b0;
        pkt_inc  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid_i && (bus.data_i == SYNC_WORD)) begin
                    state_d  = ST_FILL;
                    k_d      = '0;
                    gap_load = 1'b1;
                end else begin
                    gap_clr  = 1'b1;
                end
            end
            ST_FILL, ST_RUN: begin
                sample = bus.data_i;
                adv    = bus.in_valid_i;
                if (bus.in_valid_i) begin
                    k_d      = k_adv;
                    gap_load = 1'b1;
                    // Short packets skip RUN entirely.
                    if (k_adv == LEN_C) begin
                        state_d = ST_FLUSH;
                    end else if ((state_q == ST_FILL) && (k_adv == LAT_C)) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    gap_dec = 1'b1;
                    if (gap_tc) begin
                        state_d = ST_ABORT;
                        err_d   = 1'b1;
                        clr_d   = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                adv = 1'b1;
                k_d = k_adv;
                if (k_adv == END_C) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                    pkt_inc = 1'b1;
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign valid_d = adv && (k_adv > LAT_C) && (k_adv <= END_C);

    assign bus.start_o   = adv;
    assign bus.sample_o  = sample;
    assign bus.valid_o   = valid_q;
    assign bus.clr_o     = clr_q;
    assign bus.err_o     = err_q;
    assign bus.busy_o    = (state_q != ST_IDLE);
    assign bus.pkt_cnt_o = pkt_cnt_q;
endmodule

// File: tb/tb_demod_seq_ctrl.sv
// Directed bench for demod_seq_ctrl: a default-length instance and a PKT_LEN=4 instance.
module tb_demod_seq_ctrl;
    import demod_pkg::*;

    localparam logic [31:0] SYNC = 32'h7FFF_8000;

    logic clk;
    logic rst;
    int   cyc_n = 0;
    int   checks = 0;
    int   failures = 0;

    int a_vcnt = 0, a_ccnt = 0, a_ecnt = 0, a_fcnt = 0, a_fzcnt = 0;
    int b_vcnt = 0, b_ccnt = 0, b_fcnt = 0, b_busy = 0;

    demod_seq_ctrl_if ifa ();
    demod_seq_ctrl_if ifb ();

    demod_seq_ctrl dut_a (.clk(clk), .rst(rst), .bus(ifa));
    demod_seq_ctrl #(.PKT_LEN(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // FLUSH advances are the only ones issued while in_valid_i is low.
    always @(negedge clk) begin
        if (ifa.valid_o) a_vcnt <= a_vcnt + 1;
        if (ifa.clr_o)   a_ccnt <= a_ccnt + 1;
        if (ifa.err_o)   a_ecnt <= a_ecnt + 1;
        if (ifa.start_o && !ifa.in_valid_i) a_fcnt <= a_fcnt + 1;
        if (ifa.start_o && !ifa.in_valid_i && (ifa.sample_o == 0)) a_fzcnt <= a_fzcnt + 1;
        if (ifb.valid_o) b_vcnt <= b_vcnt + 1;
        if (ifb.clr_o)   b_ccnt <= b_ccnt + 1;
        if (ifb.start_o && !ifb.in_valid_i) b_fcnt <= b_fcnt + 1;
        if (ifb.busy_o)  b_busy <= b_busy + 1;
    end

    function automatic logic [31:0] payload(input int i);
        logic [15:0] t;
        t = 16'(i);
        return {t, ~t};
    endfunction

    task automatic a_drive(input logic v, input logic [31:0] d,
                           output logic st, output logic [31:0] smp);
        ifa.in_valid_i = v;
        ifa.data_i     = d;
        #1;
        st  = ifa.start_o;
        smp = ifa.sample_o;
        @(posedge clk);
        #1;
    endtask

    // Sync then n payload samples; optional sync word at index inj and idle gap before index gap_at.
    task automatic a_run_packet(input int n, input int inj, input int gap_at, input int gap_len,
                                output int first_lat);
        int          s;
        logic        st;
        logic [31:0] smp;
        first_lat = -1;
        s = cyc_n;
        a_drive(1'b1, SYNC, st, smp);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) a_drive(1'b0, 32'h0, st, smp);
            end
            if (ifa.valid_o && (first_lat < 0)) first_lat = cyc_n - s;
            a_drive(1'b1, (i == inj) ? SYNC : payload(i), st, smp);
            if (i == inj) begin
                checks++;
                if ((st !== 1'b1) || (smp !== SYNC)) begin
                    failures++;
                    $display("FAIL sync_as_payload: start_o=%b sample_o=%h required start_o=1 sample_o=%h",
                             st, smp, SYNC);
                end
            end
        end
        ifa.in_valid_i = 1'b0;
        ifa.data_i     = '0;
    endtask

    task automatic a_wait_idle(input string tag);
        int n;
        n = 0;
        while (ifa.busy_o && (n < 200)) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (ifa.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_timeout: busy_o=%b after %0d cycles, required 0", tag, ifa.busy_o, n);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        ifa.in_valid_i = 1'b1;
        ifa.data_i     = SYNC;
        ifb.in_valid_i = 1'b0;
        ifb.data_i     = '0;
        @(posedge clk);
        #2;
        checks++;
        if ({ifa.busy_o, ifa.start_o, ifa.valid_o, ifa.clr_o, ifa.err_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: busy,start,valid,clr,err=%b required 00000",
                     {ifa.busy_o, ifa.start_o, ifa.valid_o, ifa.clr_o, ifa.err_o});
        end
        checks++;
        if (ifa.sample_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_sample: sample_o=%h required 0", ifa.sample_o);
        end
        checks++;
        if ((ifa.pkt_cnt_o !== 16'd0) || (ifb.pkt_cnt_o !== 16'd0)) begin
            failures++;
            $display("FAIL reset_pkt_cnt: a=%0d b=%0d required 0", ifa.pkt_cnt_o, ifb.pkt_cnt_o);
        end
        ifa.in_valid_i = 1'b0;
        ifa.data_i     = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ((ifa.busy_o !== 1'b0) || (ifa.valid_o !== 1'b0)) begin
            failures++;
            $display("FAIL idle_after_release: busy_o=%b valid_o=%b required 0 0", ifa.busy_o, ifa.valid_o);
        end
    endtask

    task automatic test_full_packet();
        int v0, c0, e0, f0, z0, lat;
        v0 = a_vcnt; c0 = a_ccnt; e0 = a_ecnt; f0 = a_fcnt; z0 = a_fzcnt;
        a_run_packet(1024, -1, -1, 0, lat);
        a_wait_idle("full");
        checks++;
        if (lat !== 9) begin
            failures++;
            $display("FAIL full_first_valid: latency=%0d required 9", lat);
        end
        checks++;
        if (a_vcnt - v0 !== 1024) begin
            failures++;
            $display("FAIL full_valid_count: got %0d required 1024", a_vcnt - v0);
        end
        checks++;
        if ((a_fcnt - f0 !== 7) || (a_fzcnt - z0 !== 7)) begin
            failures++;
            $display("FAIL full_flush: advances=%0d zero_samples=%0d required 7 7", a_fcnt - f0, a_fzcnt - z0);
        end
        checks++;
        if ((a_ccnt - c0 !== 1) || (a_ecnt - e0 !== 0)) begin
            failures++;
            $display("FAIL full_clr_err: clr=%0d err=%0d required 1 0", a_ccnt - c0, a_ecnt - e0);
        end
        checks++;
        if (ifa.pkt_cnt_o !== 16'd1) begin
            failures++;
            $display("FAIL full_pkt_cnt: got %0d required 1", ifa.pkt_cnt_o);
        end
    endtask

    task automatic test_short_packet();
        int v0, c0, f0, b0;
        v0 = b_vcnt; c0 = b_ccnt; f0 = b_fcnt; b0 = b_busy;
        ifb.in_valid_i = 1'b1;
        ifb.data_i     = SYNC;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            ifb.data_i = payload(i + 100);
            @(posedge clk);
            #1;
        end
        ifb.in_valid_i = 1'b0;
        ifb.data_i     = '0;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (b_vcnt - v0 !== 4) begin
            failures++;
            $display("FAIL short_valid_count: got %0d required 4", b_vcnt - v0);
        end
        checks++;
        if (b_fcnt - f0 !== 7) begin
            failures++;
            $display("FAIL short_flush: advances=%0d required 7", b_fcnt - f0);
        end
        checks++;
        if (b_busy - b0 !== 11) begin
            failures++;
            $display("FAIL short_busy_cycles: got %0d required 11", b_busy - b0);
        end
        checks++;
        if ((b_ccnt - c0 !== 1) || (ifb.pkt_cnt_o !== 16'd1)) begin
            failures++;
            $display("FAIL short_done: clr=%0d pkt_cnt=%0d required 1 1", b_ccnt - c0, ifb.pkt_cnt_o);
        end
    endtask

    task automatic test_timeout();
        int v0, c0, e0, lat;
        v0 = a_vcnt; c0 = a_ccnt; e0 = a_ecnt;
        a_run_packet(10, -1, -1, 0, lat);
        repeat (63) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if ((ifa.busy_o !== 1'b1) || (ifa.err_o !== 1'b0)) begin
            failures++;
            $display("FAIL timeout_early: busy_o=%b err_o=%b required 1 0", ifa.busy_o, ifa.err_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({ifa.err_o, ifa.clr_o, ifa.start_o, ifa.busy_o} !== 4'b1101) begin
            failures++;
            $display("FAIL timeout_abort: err,clr,start,busy=%b required 1101",
                     {ifa.err_o, ifa.clr_o, ifa.start_o, ifa.busy_o});
        end
        @(posedge clk);
        #1;
        checks++;
        if ((ifa.busy_o !== 1'b0) || (ifa.err_o !== 1'b0)) begin
            failures++;
            $display("FAIL timeout_exit: busy_o=%b err_o=%b required 0 0", ifa.busy_o, ifa.err_o);
        end
        a_wait_idle("timeout");
        checks++;
        if ((a_ecnt - e0 !== 1) || (a_ccnt - c0 !== 1) || (a_vcnt - v0 !== 3)) begin
            failures++;
            $display("FAIL timeout_counts: err=%0d clr=%0d valid=%0d required 1 1 3",
                     a_ecnt - e0, a_ccnt - c0, a_vcnt - v0);
        end
        checks++;
        if (ifa.pkt_cnt_o !== 16'd1) begin
            failures++;
            $display("FAIL timeout_pkt_cnt: got %0d required 1", ifa.pkt_cnt_o);
        end
    endtask

    task automatic test_gap_no_abort();
        int v0, c0, e0, lat;
        v0 = a_vcnt; c0 = a_ccnt; e0 = a_ecnt;
        a_run_packet(1024, -1, 10, 63, lat);
        a_wait_idle("gap");
        checks++;
        if ((a_ecnt - e0 !== 0) || (a_ccnt - c0 !== 1) || (a_vcnt - v0 !== 1024)) begin
            failures++;
            $display("FAIL gap_counts: err=%0d clr=%0d valid=%0d required 0 1 1024",
                     a_ecnt - e0, a_ccnt - c0, a_vcnt - v0);
        end
        checks++;
        if (ifa.pkt_cnt_o !== 16'd2) begin
            failures++;
            $display("FAIL gap_pkt_cnt: got %0d required 2", ifa.pkt_cnt_o);
        end
    endtask

    task automatic test_sync_in_payload();
        int v0, f0, lat;
        v0 = a_vcnt; f0 = a_fcnt;
        a_run_packet(1024, 5, -1, 0, lat);
        a_wait_idle("syncpl");
        checks++;
        if ((a_vcnt - v0 !== 1024) || (a_fcnt - f0 !== 7)) begin
            failures++;
            $display("FAIL syncpl_counts: valid=%0d flush=%0d required 1024 7", a_vcnt - v0, a_fcnt - f0);
        end
        checks++;
        if (ifa.pkt_cnt_o !== 16'd3) begin
            failures++;
            $display("FAIL syncpl_pkt_cnt: got %0d required 3", ifa.pkt_cnt_o);
        end
    endtask

    task automatic test_reset_mid_run();
        int v0, e0, lat;
        a_run_packet(100, -1, -1, 0, lat);
        checks++;
        if (ifa.valid_o !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre_valid: valid_o=%b required 1", ifa.valid_o);
        end
        ifa.in_valid_i = 1'b1;
        ifa.data_i     = payload(3);
        rst = 1'b0;
        #1;
        checks++;
        if ({ifa.busy_o, ifa.start_o, ifa.valid_o, ifa.clr_o, ifa.err_o} !== 5'b0) begin
            failures++;
            $display("FAIL midrst_flags: busy,start,valid,clr,err=%b required 00000",
                     {ifa.busy_o, ifa.start_o, ifa.valid_o, ifa.clr_o, ifa.err_o});
        end
        checks++;
        if ((ifa.pkt_cnt_o !== 16'd0) || (ifa.sample_o !== 32'h0)) begin
            failures++;
            $display("FAIL midrst_state: pkt_cnt=%0d sample_o=%h required 0 0", ifa.pkt_cnt_o, ifa.sample_o);
        end
        @(posedge clk);
        #1;
        ifa.in_valid_i = 1'b0;
        ifa.data_i     = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        v0 = a_vcnt; e0 = a_ecnt;
        a_run_packet(1024, -1, -1, 0, lat);
        a_wait_idle("midrst");
        checks++;
        if ((a_vcnt - v0 !== 1024) || (a_ecnt - e0 !== 0) || (ifa.pkt_cnt_o !== 16'd1)) begin
            failures++;
            $display("FAIL midrst_packet: valid=%0d err=%0d pkt_cnt=%0d required 1024 0 1",
                     a_vcnt - v0, a_ecnt - e0, ifa.pkt_cnt_o);
        end
    endtask

    initial begin
        rst            = 1'b0;
        ifa.in_valid_i = 1'b0;
        ifa.data_i     = '0;
        ifb.in_valid_i = 1'b0;
        ifb.data_i     = '0;
        test_reset();
        test_full_packet();
        test_short_packet();
        test_timeout();
        test_gap_no_abort();
        test_sync_in_payload();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/demod_seq_ctrl.md
DEMOD_SEQ_CTRL -- requirements
Module: demod_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, sample component width; data bus is 2*WIDTH.
REQ-002 Parameter: SYNC_WORD, 32'h7FFF_8000, packet header word.
REQ-003 Parameter: PKT_LEN, 1024, payload samples per packet, legal range 1..65535.
REQ-004 Parameter: LATENCY, 7, datapath delay in advances, legal range 1..255.
REQ-005 Parameter: TIMEOUT, 64, maximum consecutive idle cycles inside a packet, legal range 2..65535.
REQ-006 Port: clk  in  1  single clock; all logic on the rising edge.
REQ-007 Port: rst  in  1  reset, asynchronous, active-low.
REQ-008 Port: in_valid_i  in  1  data_i carries a sample this cycle.
REQ-009 Port: data_i  in  2*WIDTH signed  {real[31:16], imag[15:0]} input sample.
REQ-010 Port: start_o  out  1  combinational datapath advance enable.
REQ-011 Port: sample_o  out  2*WIDTH  combinational sample to the datapath.
REQ-012 Port: valid_o  out  1  registered output-sample strobe.
REQ-013 Port: clr_o  out  1  registered one-cycle datapath clear pulse.
REQ-014 Port: busy_o  out  1  high in any state other than IDLE.
REQ-015 Port: err_o  out  1  registered one-cycle timeout pulse.
REQ-016 Port: pkt_cnt_o  out  16  number of completed packets, wraps from 65535 to 0.

Function
REQ-017 States: IDLE, FILL, RUN, FLUSH, ABORT.
REQ-018 IDLE: start_o=0; on in_valid_i=1 with data_i==SYNC_WORD, go to FILL next cycle; the sync word is not payload.
REQ-019 FILL/RUN: start_o=in_valid_i and sample_o=data_i; each such cycle is one "accept" and one "advance".
REQ-020 The advance counter k (1-based, cleared at sync) counts every advance in FILL, RUN and FLUSH.
REQ-021 FILL goes to RUN on the advance with k==LATENCY; if PKT_LEN<=LATENCY, FILL goes directly to FLUSH after PKT_LEN accepts.
REQ-022 RUN goes to FLUSH on the accept that makes the accepted count equal PKT_LEN.
REQ-023 FLUSH: start_o=1 every cycle and sample_o=0; exactly LATENCY advances are issued, then go to IDLE.
REQ-024 valid_o=1 in the cycle after an advance with LATENCY<k<=PKT_LEN+LATENCY, otherwise 0; exactly PKT_LEN pulses occur per completed packet.
REQ-025 On FLUSH exit: clr_o pulses for one cycle and pkt_cnt_o increments by 1.
REQ-026 Gap counter: in FILL/RUN, counts consecutive cycles with in_valid_i=0 and clears on an accept.
REQ-027 When the gap counter reaches TIMEOUT, the state goes to ABORT.
REQ-028 If in_valid_i=1 in the same cycle the gap counter would reach TIMEOUT, the accept wins and no abort occurs.
REQ-029 ABORT lasts one cycle: err_o=1, clr_o=1 and start_o=0, then the state goes to IDLE; pkt_cnt_o is unchanged.
REQ-030 SYNC_WORD received inside FILL/RUN is payload; there is no resync mid-packet.
REQ-031 in_valid_i is ignored in FLUSH and ABORT; a sync word arriving there is lost.
REQ-032 In IDLE, sample_o=0 and valid_o=0.

Reset
REQ-033 While rst=0, asynchronously: state=IDLE, all counters=0, valid_o=0, clr_o=0, err_o=0, pkt_cnt_o=0.
REQ-034 A reset mid-packet discards the packet without err_o; the first sync after reset release starts a new packet.

Structure
REQ-035 Shared package demod_pkg: state enum, SYNC_WORD default, LATENCY default, WIDTH.
REQ-036 One sub-module, gap_timer: a loadable/clearable saturating counter with a terminal-count flag, used for the timeout.

Verification
REQ-037 Sync, then 1024 back-to-back samples -> 1024 valid_o pulses, the first one 9 cycles after the sync cycle; 7 FLUSH advances with sample_o=0; clr_o pulse; pkt_cnt_o=1.
REQ-038 PKT_LEN=4, LATENCY=7 -> FILL to FLUSH directly; 4 valid_o pulses; 7 FLUSH advances.
REQ-039 Sync, 10 samples, then in_valid_i=0 for 64 cycles -> err_o and clr_o pulse once; back in IDLE; pkt_cnt_o unchanged.
REQ-040 A 63-cycle gap, then a sample on the 64th cycle -> no abort; the packet completes normally.
REQ-041 SYNC_WORD injected at payload position 5 -> counted as payload; valid_o count still 1024.
REQ-042 rst=0 asserted mid-RUN -> all outputs at reset values immediately; the next sync produces a full packet; pkt_cnt_o=1.
